// File: rtl/ctrl_fsm_waitstate.sv
// ctrl_fsm_waitstate
// Multi-cycle control FSM for the single-issue CPU. Sequences
// FETCH/DECODE/EXECUTE/MEM_WAIT/WRITEBACK/HALTED with handshakes on
// instruction fetch and data memory. It also provides a bounded memory
// timeout, single-step debug halts, edge-triggered resume, illegal-opcode
// detection and a retired-instruction counter.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   op_code         opcode of the fetched instruction (sampled in DECODE)
//   ifetch_ack      instruction memory returned the word (used in FETCH)
//   mem_ready       data memory completed the access (EXECUTE/MEM_WAIT)
//   continue_req    resume request, rising edge only. The port cannot be
//                   called "continue" because that is a SystemVerilog keyword.
//   single_step     halt after every retired instruction
//   ifetch_req      fetch request
//   loadPC          PC update enable
//   writeReg        register file write enable
//   MemEn, MemWen   data memory enable / write enable
//   IMMsel          1 = immediate, 0 = RS2
//   DataSel         writeback source: 00 ALU/MOVE, 01 memory, 10 CMOV
//   BRANCH          000 none, 001 BR, 010 BMI, 011 BPL, 100 BZ, 101 JR
//   pwr             clock-gate hint; low only in HALTED
//   halted          FSM is in HALTED
//   illegal_op      one-cycle pulse in EXECUTE for an undefined opcode
//   mem_timeout     sticky memory timeout flag; cleared only by reset
//   retired_count   retired instructions, wraps modulo 2^CNTW
//   state_dbg       current state encoding
// The datapath selects are combinational from state and op_q. This matches
// the timing of the controller that this block replaces.
module ctrl_fsm_waitstate #(
  parameter int OPW         = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNTW        = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  op_code,
  input  logic            ifetch_ack,
  input  logic            mem_ready,
  input  logic            continue_req,
  input  logic            single_step,
  output logic            ifetch_req,
  output logic            loadPC,
  output logic            writeReg,
  output logic            MemEn,
  output logic            MemWen,
  output logic            IMMsel,
  output logic [1:0]      DataSel,
  output logic [2:0]      BRANCH,
  output logic            pwr,
  output logic            halted,
  output logic            illegal_op,
  output logic            mem_timeout,
  output logic [CNTW-1:0] retired_count,
  output logic [2:0]      state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM_WAIT  = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    HC_NONE = 2'd0,
    HC_OP   = 2'd1,
    HC_STEP = 2'd2,
    HC_TMO  = 2'd3
  } cause_t;

  localparam logic [3:0] OP_ALU     = 4'h0;
  localparam logic [3:0] OP_ALU_IMM = 4'h1;
  localparam logic [3:0] OP_LOAD    = 4'h2;
  localparam logic [3:0] OP_STORE   = 4'h3;
  localparam logic [3:0] OP_BR      = 4'h4;
  localparam logic [3:0] OP_BMI     = 4'h5;
  localparam logic [3:0] OP_BPL     = 4'h6;
  localparam logic [3:0] OP_BZ      = 4'h7;
  localparam logic [3:0] OP_MOVE    = 4'h8;
  localparam logic [3:0] OP_CMOV    = 4'h9;
  localparam logic [3:0] OP_JR      = 4'hA;
  localparam logic [3:0] OP_NOP     = 4'hE;
  localparam logic [3:0] OP_HALT    = 4'hF;

  // The wait counter only needs to reach MEM_TIMEOUT-1.
  localparam int WCW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST =
    (MEM_TIMEOUT > 32'sd0) ? WCW'(MEM_TIMEOUT - 32'sd1) : {WCW{1'b0}};

  state_t            state_r, state_s;
  cause_t            cause_r, cause_s;
  logic [OPW-1:0]    op_r;
  logic [WCW-1:0]    wait_cnt_r;
  logic [CNTW-1:0]   retired_cnt_r;
  logic              tmo_r;
  logic              cont_q_r;

  logic              op_hi_nz_s;
  logic [3:0]        op_lo_s;
  logic              mem_load_s;
  logic              halt_op_s;
  state_t            retire_next_s;
  cause_t            retire_cause_s;
  logic              retire_s;
  logic              op_latch_s;
  logic              wait_clr_s;
  logic              wait_inc_s;
  logic              set_tmo_s;

  // Opcode bits above [3:0] must be zero, otherwise the opcode is illegal.
  if (OPW > 4) begin : g_wide_op
    assign op_hi_nz_s = |op_r[OPW-1:4];
  end else begin : g_narrow_op
    assign op_hi_nz_s = 1'b0;
  end

  assign op_lo_s    = op_r[3:0];
  assign mem_load_s = (op_lo_s == OP_LOAD);
  assign halt_op_s  = ~op_hi_nz_s & (op_lo_s == OP_HALT);

  // HALT takes priority over a single-step halt.
  assign retire_next_s  = (halt_op_s || single_step) ? S_HALTED : S_FETCH;
  assign retire_cause_s = halt_op_s ? HC_OP : (single_step ? HC_STEP : HC_NONE);

  assign retired_count = retired_cnt_r;
  assign mem_timeout   = tmo_r;
  assign state_dbg     = state_r;

  // Next-state, datapath selects and bookkeeping strobes.
  always_comb begin
    state_s    = state_r;
    cause_s    = cause_r;
    ifetch_req = 1'b0;
    loadPC     = 1'b0;
    writeReg   = 1'b0;
    MemEn      = 1'b0;
    MemWen     = 1'b0;
    IMMsel     = 1'b0;
    DataSel    = 2'b00;
    BRANCH     = 3'b000;
    pwr        = 1'b1;
    halted     = 1'b0;
    illegal_op = 1'b0;
    retire_s   = 1'b0;
    op_latch_s = 1'b0;
    wait_clr_s = 1'b0;
    wait_inc_s = 1'b0;
    set_tmo_s  = 1'b0;
    if (reset) begin
      // Reset wins in any state. No strobe is driven in the reset cycle.
      state_s = S_FETCH;
    end else begin
      case (state_r)
        S_FETCH: begin
          ifetch_req = 1'b1;
          state_s    = ifetch_ack ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          op_latch_s = 1'b1;
          state_s    = S_EXECUTE;
        end
        S_EXECUTE: begin
          if (op_hi_nz_s) begin
            loadPC     = 1'b1;
            illegal_op = 1'b1;
            retire_s   = 1'b1;
          end else begin
            case (op_lo_s)
              OP_ALU, OP_MOVE: begin
                writeReg = 1'b1;
                loadPC   = 1'b1;
                retire_s = 1'b1;
              end
              OP_ALU_IMM: begin
                writeReg = 1'b1;
                IMMsel   = 1'b1;
                loadPC   = 1'b1;
                retire_s = 1'b1;
              end
              OP_CMOV: begin
                writeReg = 1'b1;
                DataSel  = 2'b10;
                loadPC   = 1'b1;
                retire_s = 1'b1;
              end
              OP_BR, OP_BMI, OP_BPL, OP_BZ: begin
                IMMsel   = 1'b1;
                BRANCH   = 3'(op_lo_s - OP_BR + 4'd1);
                loadPC   = 1'b1;
                retire_s = 1'b1;
              end
              OP_JR: begin
                BRANCH   = 3'b101;
                loadPC   = 1'b1;
                retire_s = 1'b1;
              end
              OP_NOP: begin
                loadPC   = 1'b1;
                retire_s = 1'b1;
              end
              OP_HALT: begin
                retire_s = 1'b1;
              end
              OP_LOAD, OP_STORE: begin
                MemEn      = 1'b1;
                MemWen     = ~mem_load_s;
                IMMsel     = 1'b1;
                DataSel    = mem_load_s ? 2'b01 : 2'b00;
                wait_clr_s = 1'b1;
                if (!mem_ready) begin
                  state_s = S_MEM_WAIT;
                end else if (mem_load_s) begin
                  state_s = S_WRITEBACK;
                end else begin
                  loadPC   = 1'b1;
                  retire_s = 1'b1;
                end
              end
              default: begin
                loadPC     = 1'b1;
                illegal_op = 1'b1;
                retire_s   = 1'b1;
              end
            endcase
          end
        end
        S_MEM_WAIT: begin
          MemEn   = 1'b1;
          MemWen  = ~mem_load_s;
          IMMsel  = 1'b1;
          DataSel = mem_load_s ? 2'b01 : 2'b00;
          if (mem_ready) begin
            if (mem_load_s) begin
              state_s = S_WRITEBACK;
            end else begin
              loadPC   = 1'b1;
              retire_s = 1'b1;
            end
          end else if ((MEM_TIMEOUT > 32'sd0) && (wait_cnt_r == WAIT_LAST)) begin
            set_tmo_s = 1'b1;
            state_s   = S_HALTED;
            cause_s   = HC_TMO;
          end else begin
            wait_inc_s = 1'b1;
          end
        end
        S_WRITEBACK: begin
          writeReg = 1'b1;
          DataSel  = 2'b01;
          loadPC   = 1'b1;
          retire_s = 1'b1;
        end
        S_HALTED: begin
          halted = 1'b1;
          pwr    = 1'b0;
          if (continue_req && !cont_q_r) begin
            // Only a HALT opcode leaves the PC behind. A step halt has already
            // advanced the PC, and a timeout re-fetches the same instruction.
            loadPC  = (cause_r == HC_OP);
            state_s = S_FETCH;
            cause_s = HC_NONE;
          end else begin
            state_s = S_HALTED;
          end
        end
        default: begin
          state_s = S_FETCH;
        end
      endcase
      if (retire_s) begin
        state_s = retire_next_s;
        cause_s = retire_cause_s;
      end else begin
        state_s = state_s;
      end
    end
  end

  // State, latched opcode, wait counter, retire counter and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_FETCH;
      cause_r       <= HC_NONE;
      op_r          <= OPW'(OP_NOP);
      wait_cnt_r    <= {WCW{1'b0}};
      retired_cnt_r <= {CNTW{1'b0}};
      tmo_r         <= 1'b0;
      cont_q_r      <= 1'b0;
    end else begin
      state_r  <= state_s;
      cause_r  <= cause_s;
      // Sampled every cycle, so a level held high on entry to HALTED does not resume.
      cont_q_r <= continue_req;
      if (op_latch_s) begin
        op_r <= op_code;
      end
      if (wait_clr_s) begin
        wait_cnt_r <= {WCW{1'b0}};
      end else if (wait_inc_s) begin
        wait_cnt_r <= wait_cnt_r + WCW'(1'b1);
      end
      if (retire_s) begin
        retired_cnt_r <= retired_cnt_r + CNTW'(1'b1);
      end
      if (set_tmo_s) begin
        tmo_r <= 1'b1;
      end
    end
  end

endmodule
